uart_transmitter: RTL and testbench
===================================

// Module: uart_transmitter
// PURPOSE
//   Serialises one byte per request onto the UART tx line: start bit, DATA_BITS data bits LSB-first,
//   optional parity bit, then STOP_BITS stop bits. Bit timing comes from the shared
//   baud_rate_generator tick (OVERSAMPLE ticks per bit), the same tick that feeds uart_receiver.
//   Sits in the TX half of the UART top level, driven by an echo/command source and idle-high on the pin.
// PARAMETERS
//   DATA_BITS   8   data bits per frame (5..8)
//   OVERSAMPLE  16  tick_in pulses per bit period
//   STOP_BITS   1   stop bits per frame (1 or 2)
//   PARITY_EN   0   1 = append a parity bit after the data bits
//   PARITY_ODD  0   0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)
// PORTS
//   clk        in   1          system clock
//   rst        in   1          asynchronous reset, active-high
//   tick_in    in   1          1-clk baud oversample pulse from baud_rate_generator
//   tx_start   in   1          request: send data_in (sampled only in IDLE)
//   data_in    in   DATA_BITS  byte to send, captured on the accepting edge
//   tx         out  1          serial line, idle high
//   tx_busy    out  1          high from the cycle after acceptance until the frame completes
//   tx_done    out  1          1-clk pulse when the final stop bit completes
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, tx=1, tx_busy=0, tx_done=0, tick/bit counters=0.
//   - Reset mid-frame aborts the frame immediately; tx returns high with no partial stop bit.
//   States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE. All outputs are registered.
//   IDLE:
//     - tx=1.
//     - tx_start=1 at a clk edge captures data_in into a shift register, clears the tick counter,
//       and enters START.
//     - tx_busy=1 and tx=0 from the next cycle.
//   Bit timing:
//     - The tick counter advances only on tick_in=1.
//     - A bit ends on the tick_in that takes the counter from OVERSAMPLE-1 to 0.
//     - Each bit is exactly OVERSAMPLE ticks. The start bit may exceed this by under one tick period,
//       because acceptance is not tick-aligned.
//   START: tx=0 for one bit, then DATA with bit index 0.
//   DATA:
//     - tx = shift register bit 0 (LSB first); shift right at each bit end.
//     - After bit DATA_BITS-1, go to PARITY if PARITY_EN, else STOP.
//   PARITY:
//     - tx = ^data (even) or ~^data (odd), computed on the captured byte, not on data_in.
//     - Lasts one bit.
//   STOP:
//     - tx=1 for STOP_BITS bit periods.
//     - At the end of the last stop bit: state=IDLE, tx_busy=0, tx_done=1 for exactly one cycle,
//       all in the same cycle.
//   Back-to-back: tx_start high in the tx_done cycle is accepted (IDLE), so the next start bit
//     follows the stop bit with zero idle gap.
//   Requests while busy:
//     - tx_start while tx_busy=1 is ignored; it is not queued.
//     - data_in changes while busy do not affect the frame in flight.
//   Frame length: (1 + DATA_BITS + PARITY_EN + STOP_BITS) * OVERSAMPLE ticks, +<1 tick for the start bit.
//   tick_in and tx_start in the same IDLE cycle: accept; that tick is not counted toward the start bit.
//   tick_in held low: the FSM holds its state and tx holds its level indefinitely (no timeout).
// TESTING (bench: tick_in every 4 clks, OVERSAMPLE=16, i.e. 64 clk per bit)
//   1. Reset release, no tx_start
//      -> tx=1, busy=0, done=0 for 2000 clks.
//      -> Asserting rst mid-frame forces tx=1 and busy=0 asynchronously, before the next edge.
//   2. Default params, send 0x55
//      -> tx sequence 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each 64 clk (start 64..67).
//      -> done pulses once, 1 clk, at ~640 clk.
//   3. PARITY_EN=1, PARITY_ODD=0, send 0xA5 -> parity bit 0.
//      PARITY_ODD=1, send 0xA5 -> parity bit 1.
//      STOP_BITS=2 -> 2 x 64 clk high before done.
//   4. Back-to-back: assert tx_start with 0x3C in the tx_done cycle
//      -> the next start bit begins 1 clk later; no idle high beyond the stop bit.
//      -> A receiver model decodes 0x55 then 0x3C.
//   5. tx_start pulsed with 0xFF during the DATA state of 0x12
//      -> ignored; only 0x12 is sent; one done pulse.
//   6. Loopback: tx into uart_receiver sharing the same baud_rate_generator, send 0x00, 0xFF, 0x81
//      -> rx_done three times with matching data_out.

Source files
------------

// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if: baud tick, byte request and serial-line status between a byte source and the UART transmitter
interface uart_transmitter_if #(
    parameter int DATA_BITS = 8
);
    logic                 tick_in;
    logic                 tx_start;
    logic [DATA_BITS-1:0] data_in;
    logic                 tx;
    logic                 tx_busy;
    logic                 tx_done;
    modport master (output tick_in, tx_start, data_in, input tx, tx_busy, tx_done);
    modport slave  (input tick_in, tx_start, data_in, output tx, tx_busy, tx_done);
endinterface

// File: rtl/uart_transmitter.sv
// uart_transmitter: serialises one byte per request as start, LSB-first data, optional parity and stop bits
module uart_transmitter #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input logic               clk,
    input logic               rst,
    uart_transmitter_if.slave bus
);
    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               r_state, w_state_nx;
    logic [TW-1:0]        r_tick_cnt, w_tick_cnt_nx;
    logic [BW-1:0]        r_bit_cnt, w_bit_cnt_nx;
    logic [DATA_BITS-1:0] r_shift, w_shift_nx;
    logic                 r_par, w_par_nx;
    logic                 r_tx, w_tx_nx;
    logic                 r_busy, w_busy_nx;
    logic                 r_done, w_done_nx;
    logic                 w_bit_end;

    assign w_bit_end = bus.tick_in && (r_tick_cnt == TW'(OVERSAMPLE - 1));

    // tx is computed from the next state so the pin changes on the same edge as the FSM
    always_comb begin
        w_state_nx    = r_state;
        w_tick_cnt_nx = r_tick_cnt;
        w_bit_cnt_nx  = r_bit_cnt;
        w_shift_nx    = r_shift;
        w_par_nx      = r_par;
        w_tx_nx       = r_tx;
        w_busy_nx     = r_busy;
        w_done_nx     = 1'b0;
        if (r_state != S_IDLE && bus.tick_in)
            w_tick_cnt_nx = w_bit_end ? '0 : r_tick_cnt + 1'b1;
        case (r_state)
            S_IDLE: begin
                if (bus.tx_start) begin
                    w_state_nx    = S_START;
                    w_tick_cnt_nx = '0;
                    w_bit_cnt_nx  = '0;
                    w_shift_nx    = bus.data_in;
                    w_par_nx      = (^bus.data_in) ^ (PARITY_ODD != 0);
                    w_tx_nx       = 1'b0;
                    w_busy_nx     = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nx = S_DATA;
                    w_tx_nx    = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_shift_nx = r_shift >> 1;
                    if (r_bit_cnt == BW'(DATA_BITS - 1)) begin
                        w_bit_cnt_nx = '0;
                        w_state_nx   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        w_tx_nx      = (PARITY_EN != 0) ? r_par : 1'b1;
                    end else begin
                        w_bit_cnt_nx = r_bit_cnt + 1'b1;
                        w_tx_nx      = r_shift[1];
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nx = S_STOP;
                    w_tx_nx    = 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == BW'(STOP_BITS - 1)) begin
                        w_state_nx = S_IDLE;
                        w_busy_nx  = 1'b0;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_bit_cnt_nx = r_bit_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_tick_cnt <= w_tick_cnt_nx;
            r_bit_cnt  <= w_bit_cnt_nx;
            r_shift    <= w_shift_nx;
            r_par      <= w_par_nx;
            r_tx       <= w_tx_nx;
            r_busy     <= w_busy_nx;
            r_done     <= w_done_nx;
        end
    end

    assign bus.tx      = r_tx;
    assign bus.tx_busy = r_busy;
    assign bus.tx_done = r_done;
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: scoreboarded check of 8N1, 8E2 and 8O1 transmitters on a shared 1-in-4 clk baud tick
module tb_uart_transmitter;
    logic clk, rst, tick;
    int   tcnt;
    int   checks, errors;
    int   dc [3];
    logic w_tx [3], w_busy [3], w_done [3];

    typedef struct {int k; logic [7:0] d; logic p;} exp_t;
    exp_t sb_q [$];

    uart_transmitter_if #(.DATA_BITS(8)) ifa ();
    uart_transmitter_if #(.DATA_BITS(8)) ifb ();
    uart_transmitter_if #(.DATA_BITS(8)) ifc ();

    uart_transmitter #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0))
        u_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    uart_transmitter #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(0))
        u_b (.clk(clk), .rst(rst), .bus(ifb.slave));
    uart_transmitter #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1))
        u_c (.clk(clk), .rst(rst), .bus(ifc.slave));

    assign ifa.tick_in = tick;
    assign ifb.tick_in = tick;
    assign ifc.tick_in = tick;
    assign w_tx[0] = ifa.tx;      assign w_busy[0] = ifa.tx_busy;  assign w_done[0] = ifa.tx_done;
    assign w_tx[1] = ifb.tx;      assign w_busy[1] = ifb.tx_busy;  assign w_done[1] = ifb.tx_done;
    assign w_tx[2] = ifc.tx;      assign w_busy[2] = ifc.tx_busy;  assign w_done[2] = ifc.tx_done;

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        tcnt = 0;
        tick = 0;
        forever begin
            @(negedge clk);
            tcnt = tcnt + 1;
            tick = (tcnt % 4 == 0);
        end
    end

    always @(negedge clk)
        for (int i = 0; i < 3; i++)
            if (w_done[i] === 1'b1) dc[i] <= dc[i] + 1;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic req(input int k, input logic s, input logic [7:0] d);
        if (k == 0) begin ifa.tx_start = s; ifa.data_in = d; end
        else if (k == 1) begin ifb.tx_start = s; ifb.data_in = d; end
        else begin ifc.tx_start = s; ifc.data_in = d; end
    endtask

    // mode 0: next negedge, 1: in a tick cycle, 2: right now (already at a negedge)
    task automatic send(input int k, input logic [7:0] d, input int mode, input bit push);
        logic p;
        if (mode == 0) @(negedge clk);
        if (mode == 1) do begin @(negedge clk); #1; end while (!tick);
        req(k, 1'b1, d);
        p = (($countones(d) % 2) != 0) ^ (k == 2);
        if (push) sb_q.push_back('{k: k, d: d, p: p});
        @(negedge clk);
        req(k, 1'b0, d);
        chk($sformatf("start_tx%0d_%h", k, d), w_tx[k], 0);
        chk($sformatf("start_busy%0d_%h", k, d), w_busy[k], 1);
    endtask

    task automatic wait_done(input int k, output int c, output int run);
        int hi, nb;
        c = 0; hi = 0; nb = 0;
        forever begin
            @(negedge clk);
            c++;
            if (w_done[k] === 1'b1 || c > 3000) break;
            if (w_busy[k] !== 1'b1) nb++;
            hi = (w_tx[k] === 1'b1) ? hi + 1 : 0;
        end
        run = hi;
        chk($sformatf("done%0d", k), w_done[k], 1);
        chk($sformatf("busy_clr%0d", k), w_busy[k], 0);
        chk($sformatf("busy_hold%0d", k), nb, 0);
    endtask

    // receiver model: mid-bit sampling, false starts are ignored
    task automatic monitor(input int k);
        logic [7:0] d;
        logic       p, s;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst || w_tx[k] !== 1'b0) continue;
            repeat (32) @(negedge clk);
            if (w_tx[k] !== 1'b0) continue;
            for (int i = 0; i < 8; i++) begin
                repeat (64) @(negedge clk);
                d[i] = w_tx[k];
            end
            p = 1'b0;
            if (k != 0) begin
                repeat (64) @(negedge clk);
                p = w_tx[k];
            end
            s = 1'b1;
            for (int i = 0; i < ((k == 1) ? 2 : 1); i++) begin
                repeat (64) @(negedge clk);
                s &= w_tx[k];
            end
            if (sb_q.size() == 0 || sb_q[0].k != k) begin
                checks++;
                errors++;
                $display("FAIL frame%0d unexpected byte got %h", k, d);
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("data%0d", k), d, e.d);
                if (k != 0) chk($sformatf("parity%0d_%h", k, e.d), p, e.p);
                chk($sformatf("stop%0d_%h", k, e.d), s, 1);
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);

    initial begin
        int c, run, bad;
        checks = 0; errors = 0;
        rst = 1;
        req(0, 0, 0); req(1, 0, 0); req(2, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_tx", {w_tx[0], w_tx[1], w_tx[2]}, 3'b111);
        chk("rst_busy", {w_busy[0], w_busy[1], w_busy[2]}, 3'b000);
        chk("rst_done", {w_done[0], w_done[1], w_done[2]}, 3'b000);
        rst = 0;
        bad = 0;
        repeat (2000) begin
            @(negedge clk);
            if (w_tx[0] !== 1'b1 || w_busy[0] !== 1'b0 || w_done[0] !== 1'b0) bad++;
        end
        chk("idle_2000", bad, 0);
        // 0x55 accepted in a tick cycle, then 0x3C back-to-back in the done cycle
        send(0, 8'h55, 1, 1);
        wait_done(0, c, run);
        chk("len_55", c, 640);
        chk("stop_55", run, 64);
        send(0, 8'h3C, 2, 1);
        wait_done(0, c, run);
        chk("stop_3c", run, 64);
        // request while busy is dropped
        repeat (10) @(negedge clk);
        send(0, 8'h12, 0, 1);
        repeat (200) @(negedge clk);
        req(0, 1, 8'hFF);
        @(negedge clk);
        req(0, 0, 8'hFF);
        wait_done(0, c, run);
        chk("stop_12", run, 64);
        send(0, 8'h00, 0, 1);
        wait_done(0, c, run);
        chk("stop_00", run, 64);
        send(0, 8'hFF, 0, 1);
        wait_done(0, c, run);
        chk("high_ff", run, 576);
        send(0, 8'h81, 0, 1);
        wait_done(0, c, run);
        chk("high_81", run, 128);
        // parity variants
        send(1, 8'hA5, 1, 1);
        wait_done(1, c, run);
        chk("len_e2", c, 768);
        chk("stop_e2", run, 128);
        send(2, 8'hA5, 1, 1);
        wait_done(2, c, run);
        chk("len_o1", c, 704);
        chk("high_o1", run, 192);
        // abort mid start bit
        send(0, 8'h99, 0, 0);
        repeat (20) @(negedge clk);
        #2;
        rst = 1;
        #1;
        chk("abort_tx", w_tx[0], 1);
        chk("abort_busy", w_busy[0], 0);
        repeat (2) @(negedge clk);
        rst = 0;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (w_tx[0] !== 1'b1 || w_busy[0] !== 1'b0 || w_done[0] !== 1'b0) bad++;
        end
        chk("idle_after_abort", bad, 0);
        chk("sb_empty", sb_q.size(), 0);
        chk("done_cnt_a", dc[0], 6);
        chk("done_cnt_b", dc[1], 1);
        chk("done_cnt_c", dc[2], 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
